// File: rtl/tlul_arb_pkg.sv
// Shared definitions for the TL-UL host arbiter: grant FSM states and
// the host-ID width helper.
package tlul_arb_pkg;

    typedef enum logic {
        StIdle,
        StLocked
    } arb_state_e;

    // A single host still needs one bit of ID storage.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types shared by hosts, devices and the arbiter.
// Field set matches the subset of TL-UL that this crossbar slice carries.
package tlul_pkg;

    typedef struct packed {
        logic        a_valid;
        logic [2:0]  a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        logic [2:0]  d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic        d_sink;
        logic [31:0] d_data;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

endpackage

// File: rtl/tlul_arb_idq.sv
// In-order queue of granted host IDs; the head names the host that owns
// the next device response.
module tlul_arb_idq #(
    parameter int unsigned Width = 2,
    parameter int unsigned Depth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [Width-1:0]         push_id_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = {{PtrW{1'b0}}, 1'b1};

    logic [PtrW:0]      wptr_q, rptr_q;
    logic [Width-1:0]   mem_q [Depth];
    logic               do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                     (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
    assign count_o = wptr_q - rptr_q;
    assign head_o  = mem_q[rptr_q[PtrW-1:0]];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + PtrOne;
            if (do_pop)  rptr_q <= rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[PtrW-1:0]] <= push_id_i;
    end

endmodule

// File: rtl/tlul_host_arb.sv
// Round-robin arbiter sharing one TL-UL device port among several hosts,
// with a grant lock on the A channel and in-order D-channel routing.
module tlul_host_arb
    import tlul_pkg::*;
    import tlul_arb_pkg::*;
#(
    parameter int unsigned NumHosts       = 3,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned HostIdW        = id_width(NumHosts)
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  tl_h2d_t tl_h_i [NumHosts],
    output tl_d2h_t tl_h_o [NumHosts],
    output tl_h2d_t tl_d_o,
    input  tl_d2h_t tl_d_i,
    output logic    err_o,
    output logic    busy_o
);

    arb_state_e                      state_q, state_d;
    logic [HostIdW-1:0]              lock_id_q, lock_id_d;
    logic [HostIdW-1:0]              last_q, last_d;
    logic [HostIdW-1:0]              gnt_id, cand, head_id;
    logic                            gnt_valid;
    logic                            full, empty, a_acc, d_acc, pop;
    logic [$clog2(MaxOutstanding):0] cnt;

    // Grant depends only on registered state and host a_valid, never on a_ready.
    always_comb begin
        gnt_id    = last_q;
        gnt_valid = 1'b0;
        cand      = '0;
        if (state_q == StLocked) begin
            gnt_id    = lock_id_q;
            gnt_valid = tl_h_i[lock_id_q].a_valid;
        end else begin
            for (int unsigned i = 1; i <= NumHosts; i++) begin
                cand = HostIdW'((32'(last_q) + i) % NumHosts);
                if (!gnt_valid && tl_h_i[cand].a_valid) begin
                    gnt_valid = 1'b1;
                    gnt_id    = cand;
                end
            end
        end
    end

    always_comb begin
        tl_d_o         = tl_h_i[gnt_id];
        tl_d_o.a_valid = gnt_valid & ~full & ~rst_i;
        // An empty queue drains unexpected responses instead of stalling the device.
        tl_d_o.d_ready = ~rst_i & (empty | tl_h_i[head_id].d_ready);
        for (int unsigned i = 0; i < NumHosts; i++) begin
            tl_h_o[i] = '0;
            if (!rst_i && !empty && (HostIdW'(i) == head_id)) begin
                tl_h_o[i]         = tl_d_i;
                tl_h_o[i].a_ready = 1'b0;
            end
            if (!rst_i && (HostIdW'(i) == gnt_id)) begin
                tl_h_o[i].a_ready = tl_d_i.a_ready & ~full;
            end
        end
    end

    assign a_acc  = tl_d_o.a_valid & tl_d_i.a_ready;
    assign d_acc  = tl_d_i.d_valid & tl_d_o.d_ready;
    assign pop    = d_acc & ~empty;
    assign err_o  = d_acc & empty;
    assign busy_o = ~rst_i & (cnt != '0);

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        last_d    = a_acc ? gnt_id : last_q;
        case (state_q)
            StIdle: begin
                if (gnt_valid && !a_acc) begin
                    state_d   = StLocked;
                    lock_id_d = gnt_id;
                end
            end
            StLocked: begin
                if (a_acc) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            lock_id_q <= '0;
            last_q    <= HostIdW'(NumHosts - 1);
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            last_q    <= last_d;
        end
    end

    tlul_arb_idq #(
        .Width (HostIdW),
        .Depth (MaxOutstanding)
    ) u_idq (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (a_acc),
        .push_id_i (gnt_id),
        .pop_i     (pop),
        .head_o    (head_id),
        .empty_o   (empty),
        .full_o    (full),
        .count_o   (cnt)
    );

endmodule

// File: doc/tlul_host_arb.md
# tlul_host_arb

Round-robin arbiter that shares one TL-UL device port among `NumHosts` TL-UL hosts. It sits between host-side crossbar ports and a single downstream device or FIFO. It muxes A-channel requests with a grant lock that keeps each request stable until it is accepted. It routes D-channel responses back to the issuing host using an in-order queue of host IDs, and stalls new requests once `MaxOutstanding` transactions are in flight.

## Interface
- `NumHosts`, default 3, number of upstream hosts (2..8)
- `MaxOutstanding`, default 4, depth of the host-ID queue (power of two, 2..16)
- `HostIdW`, default `$clog2(NumHosts)`, width of the stored host ID (derived; do not override)
- `clk_i  input  1  clock`
- `rst_i  input  1  reset, synchronous, active-high`
- `tl_h_i  input  tl_h2d_t [NumHosts]  host requests and host `d_ready``
- `tl_h_o  output  tl_d2h_t [NumHosts]  per-host `a_ready` and routed responses`
- `tl_d_o  output  tl_h2d_t  granted request to the device, plus `d_ready``
- `tl_d_i  input  tl_d2h_t  device `a_ready` and responses`
- `err_o  output  1  one-cycle pulse when the device returns a response with no outstanding entry`
- `busy_o  output  1  high while the outstanding count is non-zero`

## Operation
- Outstanding count `cnt` ranges 0..MaxOutstanding. It increments on each A accept (`tl_d_o.a_valid & tl_d_i.a_ready`) and decrements on each D accept (`tl_d_i.d_valid & tl_d_o.d_ready`). When both happen in the same cycle, `cnt` is unchanged.
- Arbiter states:
  - IDLE: no lock. Grant goes to the first requesting host (`a_valid`) scanning upward from `last+1`, modulo NumHosts.
  - LOCKED: entered when the granted request is not accepted in its cycle. The grant is held on `lock_id` regardless of other requests. LOCKED returns to IDLE on the cycle that request is accepted.
- `last` updates to the granted ID on every A accept. Reset value of `last` is NumHosts-1, so host 0 has highest priority first.
- Full stall: when `cnt == MaxOutstanding`, `tl_d_o.a_valid` is 0 and every `a_ready` is 0. This holds even if a D accept occurs in the same cycle. The lock is preserved through the stall.
- A-channel data: every `tl_d_o` A-field equals the granted host's field. `tl_d_o.a_valid` = granted `a_valid` & !full. Only the granted host sees `a_ready = tl_d_i.a_ready & !full`; all other hosts see 0.
- On A accept, the granted ID is pushed onto the ID queue.
- D-channel routing:
  - The head ID `h` selects the host. `tl_h_o[h]` carries every D-field of `tl_d_i`, with `d_valid = tl_d_i.d_valid`. Every other host sees `d_valid = 0` and D-fields at zero.
  - `tl_d_o.d_ready = tl_h_i[h].d_ready`.
  - On D accept, the queue pops.
- The device must respond in request order; `a_source` passes through unmodified.
- Queue empty with `tl_d_i.d_valid = 1`: `tl_d_o.d_ready` = 1 so the response is drained, no host sees `d_valid`, `err_o` pulses for 1 cycle, and `cnt` stays at 0.
- Reset mid-operation: the queue and `cnt` are cleared and the lock is dropped. Outstanding responses arriving later are treated as unexpected (drained, with `err_o`).

## Timing
- Request path is combinational from host to device: 0-cycle latency and no added bubbles. Back-to-back accepts are allowed every cycle.
- Response path is combinational from device to host: 0-cycle latency.
- Reset values:
  - all `tl_h_o` = 0 (`a_ready` and `d_valid` low)
  - `tl_d_o.a_valid` = 0
  - `tl_d_o.d_ready` = 0 while reset is asserted
  - `err_o` = 0, `busy_o` = 0
  - state IDLE, `cnt` = 0, `last` = NumHosts-1
- Registered state: `lock`, `lock_id`, `last`, queue pointers, and `cnt`. All update on the `clk_i` edge.
- There is no combinational path from `tl_d_i.a_ready` to any grant decision. A host can only observe the effect of `a_ready` one cycle later, through the lock.

## Structure
- Shared package `tlul_arb_pkg` holds the ID-width helper function and the arbiter state enum (IDLE, LOCKED).
- TL-UL types come from `tlul_pkg`.
- One natural sub-module, `tlul_arb_idq`:
  - synchronous ID FIFO of width HostIdW and depth MaxOutstanding
  - ports for push, pop, head, empty, full and count
  - same clock and reset as the parent
  - wrap-around via pointers with an extra MSB

## Test plan
- Hosts 0, 1 and 2 all request in cycle 0 with device `a_ready` = 1 → grants in order 0, 1, 2 on cycles 0, 1, 2; responses returned in order reach hosts 0, 1, 2 respectively.
- Host 1 requests while device `a_ready` = 0 for 3 cycles, and host 0 raises a request in cycle 1 → grant stays on host 1 until accept in cycle 3; host 0 is granted in cycle 4.
- MaxOutstanding = 4: four accepts with no responses → fifth request sees `a_ready` = 0. A D accept plus a new request in the same cycle → request still stalled that cycle and accepted the next cycle.
- Host 2 response held with `tl_h_i[2].d_ready` = 0 for 2 cycles → `tl_d_o.d_ready` = 0, the queue does not pop, and no other host sees `d_valid`.
- Device `d_valid` with an empty queue → `d_ready` = 1, `err_o` is a 1-cycle pulse, `cnt` = 0, no host `d_valid`.
- `rst_i` asserted with 3 outstanding and host 1 locked → next cycle `cnt` = 0, `busy_o` = 0, state IDLE, host 0 has highest priority.
